// File: rtl/fp_sqrt_seq.sv
// Sequential IEEE-754 square root: one root bit per clock via a non-restoring
// integer recurrence, then a single rounding cycle, behind valid/ready handshakes.
module fp_sqrt_seq #(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int ROUND_MODE = 1,
    localparam int W         = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_invalid,
    output logic         out_inexact
);

    localparam int Q     = MAN_W + 2;
    localparam int CNT_W = $clog2(Q);
    localparam logic [EXP_W-1:0] BIAS     = EXP_W'((1 << (EXP_W - 1)) - 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

    state_t             state_reg, state_next;
    logic [2*Q-1:0]     rad_reg, rad_next;
    logic [Q+1:0]       rem_reg, rem_next;
    logic [Q-1:0]       root_reg, root_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [EXP_W-1:0]   exp_reg, exp_next;
    logic [W-1:0]       result_reg, result_next;
    logic               invalid_reg, invalid_next;
    logic               inexact_reg, inexact_next;

    logic               in_sign;
    logic [EXP_W-1:0]   in_exp;
    logic [MAN_W-1:0]   in_frac;
    logic               exp_max, exp_zero, frac_zero;
    logic [EXP_W:0]     e_unb;
    logic [EXP_W-1:0]   res_exp;

    assign in_sign   = in_a[W-1];
    assign in_exp    = in_a[W-2 -: EXP_W];
    assign in_frac   = in_a[MAN_W-1:0];
    assign exp_max   = (in_exp == EXP_ONES);
    assign exp_zero  = (in_exp == '0);
    assign frac_zero = (in_frac == '0);

    // Unbiased exponent halved with an arithmetic shift, so odd values round toward -inf
    // and the odd case is compensated by a one-bit-wider radicand shift.
    assign e_unb   = {1'b0, in_exp} - {1'b0, BIAS};
    assign res_exp = {e_unb[EXP_W], e_unb[EXP_W-1:1]} + BIAS;

    logic [Q+1:0]       rem_shift, rem_step, rem_fix;
    logic               guard, sticky, round_up, frac_carry;
    logic [MAN_W-1:0]   frac_rnd;

    assign rem_shift = {rem_reg[Q-1:0], rad_reg[2*Q-1 -: 2]};
    assign rem_step  = rem_reg[Q+1] ? rem_shift + {root_reg, 2'b11}
                                    : rem_shift - {root_reg, 2'b01};

    // A negative final remainder is restored before it is used as the sticky source.
    assign rem_fix  = rem_reg[Q+1] ? rem_reg + {1'b0, root_reg, 1'b1} : rem_reg;
    assign sticky   = |rem_fix;
    assign guard    = root_reg[0];
    assign round_up = (ROUND_MODE == 1) && guard && (sticky || root_reg[1]);
    assign {frac_carry, frac_rnd} = {1'b0, root_reg[Q-2:1]} + (MAN_W+1)'(round_up);

    always_comb begin
        state_next   = state_reg;
        rad_next     = rad_reg;
        rem_next     = rem_reg;
        root_next    = root_reg;
        cnt_next     = cnt_reg;
        exp_next     = exp_reg;
        result_next  = result_reg;
        invalid_next = invalid_reg;
        inexact_next = inexact_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    invalid_next = 1'b0;
                    inexact_next = 1'b0;
                    state_next   = DONE;
                    if (exp_max) begin
                        if (!frac_zero) begin
                            result_next  = QNAN;
                            invalid_next = ~in_frac[MAN_W-1];
                        end else if (in_sign) begin
                            result_next  = QNAN;
                            invalid_next = 1'b1;
                        end else begin
                            result_next = in_a;
                        end
                    end else if (exp_zero) begin
                        result_next = {in_sign, {(W-1){1'b0}}};
                    end else if (in_sign) begin
                        result_next  = QNAN;
                        invalid_next = 1'b1;
                    end else begin
                        state_next = CALC;
                        rad_next   = e_unb[0] ? {1'b1, in_frac, {(MAN_W+3){1'b0}}}
                                              : {2'b01, in_frac, {(MAN_W+2){1'b0}}};
                        rem_next   = '0;
                        root_next  = '0;
                        cnt_next   = '0;
                        exp_next   = res_exp;
                    end
                end
            end
            CALC: begin
                rad_next  = rad_reg << 2;
                rem_next  = rem_step;
                root_next = {root_reg[Q-2:0], ~rem_step[Q+1]};
                cnt_next  = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(Q - 1)) begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                result_next  = {1'b0, exp_reg + EXP_W'(frac_carry), frac_rnd};
                inexact_next = guard | sticky;
                invalid_next = 1'b0;
                state_next   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            rad_reg     <= '0;
            rem_reg     <= '0;
            root_reg    <= '0;
            cnt_reg     <= '0;
            exp_reg     <= '0;
            result_reg  <= '0;
            invalid_reg <= 1'b0;
            inexact_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rad_reg     <= rad_next;
            rem_reg     <= rem_next;
            root_reg    <= root_next;
            cnt_reg     <= cnt_next;
            exp_reg     <= exp_next;
            result_reg  <= result_next;
            invalid_reg <= invalid_next;
            inexact_reg <= inexact_next;
        end
    end

    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign out_result  = result_reg;
    assign out_invalid = invalid_reg;
    assign out_inexact = inexact_reg;

endmodule

// File: tb/tb_fp_sqrt_seq.sv
// Bench for fp_sqrt_seq: single precision in both rounding modes (lock-stepped)
// and a half-precision instance, checked against an integer-sqrt reference model.
module tb_fp_sqrt_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid;
    logic [31:0] in_a;
    logic        out_ready;
    logic        a_in_ready, a_out_valid, a_inv, a_inx;
    logic [31:0] a_res;
    logic        b_in_ready, b_out_valid, b_inv, b_inx;
    logic [31:0] b_res;
    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_inv, h_inx;
    logic [15:0] h_in_a, h_res;

    fp_sqrt_seq #(.EXP_W(8), .MAN_W(23), .ROUND_MODE(1)) dut_rne (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready), .in_a(in_a),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_result(a_res),
        .out_invalid(a_inv), .out_inexact(a_inx));

    fp_sqrt_seq #(.EXP_W(8), .MAN_W(23), .ROUND_MODE(0)) dut_trn (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready), .in_a(in_a),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_result(b_res),
        .out_invalid(b_inv), .out_inexact(b_inx));

    fp_sqrt_seq #(.EXP_W(5), .MAN_W(10), .ROUND_MODE(1)) dut_half (
        .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready), .in_a(h_in_a),
        .out_valid(h_out_valid), .out_ready(h_out_ready), .out_result(h_res),
        .out_invalid(h_inv), .out_inexact(h_inx));

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: root = largest r with r*r <= radicand, remainder gives sticky.
    // Returns {invalid, inexact, result}.
    function automatic logic [33:0] ref_sqrt(input logic [31:0] a, input int ew, input int mw,
                                             input bit rne);
        longint unsigned n, r, c, rem, frac, m;
        int expf, e, eh, bias, expmax;
        bit sign, odd, g, t;
        logic [31:0] qnan, res;
        expmax = (1 << ew) - 1;
        bias   = (1 << (ew - 1)) - 1;
        sign   = a[ew+mw];
        expf   = int'((a >> mw) & expmax);
        frac   = longint'(a) & ((64'd1 << mw) - 1);
        qnan   = 32'((expmax << mw) | (1 << (mw - 1)));
        if (expf == expmax) begin
            if (frac != 0) return {!a[mw-1], 1'b0, qnan};
            if (sign) return {2'b10, qnan};
            return {2'b00, a};
        end
        if (expf == 0) begin
            res = '0;
            res[ew+mw] = sign;
            return {2'b00, res};
        end
        if (sign) return {2'b10, qnan};
        e   = expf - bias;
        odd = (e % 2) != 0;
        eh  = odd ? (e - 1) / 2 : e / 2;
        m   = (64'd1 << mw) | frac;
        n   = m << (mw + 2 + int'(odd));
        r   = 0;
        for (int b = 31; b >= 0; b--) begin
            c = r | (64'd1 << b);
            if (c * c <= n) r = c;
        end
        rem  = n - r * r;
        g    = r[0];
        t    = (rem != 0);
        frac = (r >> 1) & ((64'd1 << mw) - 1);
        if (rne && g && (t || frac[0])) frac++;
        if (frac == (64'd1 << mw)) begin
            frac = 0;
            eh++;
        end
        res = 32'((longint'(eh + bias) << mw) | frac);
        return {1'b0, g | t, res};
    endfunction

    task automatic run32(input logic [31:0] a, input int exp_lat, input bit has_want,
                         input logic [33:0] want, input string tag);
        int lat;
        logic [33:0] e1, e0;
        e1 = ref_sqrt(a, 8, 23, 1'b1);
        e0 = ref_sqrt(a, 8, 23, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!(a_out_valid && b_out_valid) && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, " valid"}, {32'd0, a_out_valid, b_out_valid}, {32'd0, 2'b11});
        if (exp_lat > 0) check({tag, " latency"}, 34'(lat), 34'(exp_lat));
        if (has_want) check({tag, " const"}, {a_inv, a_inx, a_res}, want);
        check({tag, " rne"}, {a_inv, a_inx, a_res}, e1);
        check({tag, " trunc"}, {b_inv, b_inx, b_res}, e0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run16(input logic [15:0] a, input int exp_lat, input bit has_want,
                         input logic [33:0] want, input string tag);
        int lat;
        logic [33:0] e1;
        e1 = ref_sqrt({16'd0, a}, 5, 10, 1'b1);
        @(negedge clk);
        h_in_valid = 1'b1;
        h_in_a     = a;
        @(posedge clk);
        #1 h_in_valid = 1'b0;
        lat = 1;
        while (!h_out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, " valid"}, {33'd0, h_out_valid}, 34'd1);
        if (exp_lat > 0) check({tag, " latency"}, 34'(lat), 34'(exp_lat));
        if (has_want) check({tag, " const"}, {h_inv, h_inx, 16'd0, h_res}, want);
        check({tag, " model"}, {h_inv, h_inx, 16'd0, h_res}, e1);
        h_out_ready = 1'b1;
        @(posedge clk);
        #1 h_out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [33:0] e3;
        logic [31:0] ra;
        logic [15:0] rh;
        reset = 1'b1;
        in_valid = 1'b0; in_a = '0; out_ready = 1'b0;
        h_in_valid = 1'b0; h_in_a = '0; h_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset state", {28'd0, a_in_ready, a_out_valid, a_inv, a_inx, b_in_ready, b_out_valid},
              {28'd0, 6'b100010});
        check("reset result", {2'b00, a_res}, 34'd0);
        check("reset half", {h_inv, h_inx, 16'd0, h_res}, 34'd0);
        @(negedge clk);
        reset = 1'b0;

        run32(32'h40800000, 27, 1'b1, {2'b00, 32'h40000000}, "sqrt 4.0");
        run32(32'h3E800000, 27, 1'b1, {2'b00, 32'h3F000000}, "sqrt 0.25");
        run32(32'h40000000, 27, 1'b1, {2'b01, 32'h3FB504F3}, "sqrt 2.0");
        run32(32'h40400000, 27, 1'b1, {2'b01, 32'h3FDDB3D7}, "sqrt 3.0");
        run32(32'hBF800000, 1, 1'b1, {2'b10, 32'h7FC00000}, "neg one");
        run32(32'h80000000, 1, 1'b1, {2'b00, 32'h80000000}, "neg zero");
        run32(32'h00000000, 1, 1'b1, {2'b00, 32'h00000000}, "pos zero");
        run32(32'h7F800000, 1, 1'b1, {2'b00, 32'h7F800000}, "pos inf");
        run32(32'hFF800000, 1, 1'b1, {2'b10, 32'h7FC00000}, "neg inf");
        run32(32'h7F800001, 1, 1'b1, {2'b10, 32'h7FC00000}, "snan");
        run32(32'hFFC00123, 1, 1'b1, {2'b00, 32'h7FC00000}, "qnan");
        run32(32'h00000001, 1, 1'b1, {2'b00, 32'h00000000}, "denormal");
        run32(32'h807FFFFF, 1, 1'b1, {2'b00, 32'h80000000}, "neg denormal");

        // Backpressure: result held, new operands ignored while DONE.
        e3 = ref_sqrt(32'h40400000, 8, 23, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        in_a = 32'h40400000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_a = 32'h40800000;
            @(posedge clk);
            #1;
            check($sformatf("stall hold %0d", i), {a_inv, a_inx, a_res}, e3);
            check($sformatf("stall flags %0d", i), {32'd0, a_out_valid, a_in_ready}, {32'd0, 2'b10});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("release", {32'd0, a_in_ready, a_out_valid}, {32'd0, 2'b10});
        @(posedge clk);
        #1;
        check("no queued op", {32'd0, a_in_ready, a_out_valid}, {32'd0, 2'b10});

        // Reset in the middle of CALC aborts silently.
        @(negedge clk);
        in_valid = 1'b1;
        in_a = 32'h40000000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort state", {32'd0, a_in_ready, a_out_valid}, {32'd0, 2'b10});
        repeat (30) @(posedge clk);
        #1;
        check("abort silent", {33'd0, a_out_valid}, 34'd0);
        run32(32'h41100000, 27, 1'b1, {2'b00, 32'h40400000}, "sqrt 9.0");

        run16(16'h4400, 14, 1'b1, {2'b00, 32'h00004000}, "half 4.0");
        run16(16'h3C00, 14, 1'b1, {2'b00, 32'h00003C00}, "half 1.0");
        run16(16'h4000, 14, 1'b1, {2'b01, 32'h00003DA8}, "half 2.0");
        run16(16'h7C01, 1, 1'b1, {2'b10, 32'h00007E00}, "half snan");

        for (int i = 0; i < 700; i++) begin
            ra = $urandom;
            run32(ra, 0, 1'b0, 34'd0, $sformatf("rnd32 %h", ra));
        end
        for (int i = 0; i < 2500; i++) begin
            rh = 16'($urandom);
            run16(rh, 0, 1'b0, 34'd0, $sformatf("rnd16 %h", rh));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
